// File: rtl/eigen_iteration_ctrl.sv
// eigen_iteration_ctrl: power-iteration sequencer driving a step unit and a convergence checker; EIGEN_ITER_TIMEOUT_EN adds an iteration limit
module eigen_iteration_ctrl #(
    parameter int SIZE_N = 8,
    parameter int MAX_ITER = 64,
    localparam int VW = 64 * SIZE_N,
    localparam int CW = $clog2(MAX_ITER + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [VW-1:0] init_vector,
    output logic          step_start,
    input  logic [VW-1:0] step_vector,
    input  logic          step_f,
    output logic          chk_start,
    input  logic          chk_f,
    input  logic          chk_converged,
    output logic [VW-1:0] vector,
    output logic [VW-1:0] next_vector,
    output logic          busy,
    output logic          f,
    output logic          converged,
    output logic          timeout,
    output logic [CW-1:0] iter_count
);
    typedef enum logic [2:0] {IDLE, STEP, CHECK, UPDATE, DONE} state_t;
    state_t state;
    logic [CW-1:0] iter_inc;
    logic limit_hit;
    // saturating increment; the limit only matters when the timeout feature is built in
    always_comb begin
        iter_inc = (iter_count == {CW{1'b1}}) ? iter_count : iter_count + CW'(1);
`ifdef EIGEN_ITER_TIMEOUT_EN
        limit_hit = iter_inc == CW'(MAX_ITER);
`else
        limit_hit = 1'b0;
`endif
    end
`ifndef EIGEN_ITER_TIMEOUT_EN
    assign timeout = 1'b0;
`endif
    // sequencer: every output is a register updated alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            step_start  <= 1'b0;
            chk_start   <= 1'b0;
            busy        <= 1'b0;
            f           <= 1'b0;
            converged   <= 1'b0;
            iter_count  <= '0;
            vector      <= '0;
            next_vector <= '0;
`ifdef EIGEN_ITER_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    vector     <= init_vector;
                    iter_count <= '0;
                    converged  <= 1'b0;
`ifdef EIGEN_ITER_TIMEOUT_EN
                    timeout    <= 1'b0;
`endif
                    busy       <= 1'b1;
                    step_start <= 1'b1;
                    state      <= STEP;
                end
                STEP: if (step_f) begin
                    next_vector <= step_vector;
                    step_start  <= 1'b0;
                    chk_start   <= 1'b1;
                    state       <= CHECK;
                end
                CHECK: if (chk_f) begin
                    chk_start  <= 1'b0;
                    iter_count <= iter_inc;
                    if (chk_converged || limit_hit) begin
                        converged <= chk_converged;
`ifdef EIGEN_ITER_TIMEOUT_EN
                        timeout   <= !chk_converged;
`endif
                        f         <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    vector     <= next_vector;
                    step_start <= 1'b1;
                    state      <= STEP;
                end
                DONE: begin
                    f     <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eigen_iteration_ctrl.sv
// tb_eigen_iteration_ctrl: directed checks of the iteration sequencer with SIZE_N=4, MAX_ITER=3
module tb_eigen_iteration_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [255:0] init_vector = '0;
    logic step_start;
    logic [255:0] step_vector = '0;
    logic step_f = 1'b0;
    logic chk_start;
    logic chk_f = 1'b0;
    logic chk_converged = 1'b0;
    logic [255:0] vector;
    logic [255:0] next_vector;
    logic busy, f, converged, timeout;
    logic [1:0] iter_count;
    int n_cmp = 0;
    int n_bad = 0;

    eigen_iteration_ctrl #(.SIZE_N(4), .MAX_ITER(3)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vector(init_vector),
        .step_start(step_start), .step_vector(step_vector), .step_f(step_f),
        .chk_start(chk_start), .chk_f(chk_f), .chk_converged(chk_converged),
        .vector(vector), .next_vector(next_vector), .busy(busy), .f(f),
        .converged(converged), .timeout(timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] vec4(real a, real b, real c, real d);
        return {$realtobits(d), $realtobits(c), $realtobits(b), $realtobits(a)};
    endfunction

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic [255:0] v);
        init_vector = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_step(logic [255:0] v);
        for (int i = 0; i < 20 && !step_start; i++) tick();
        if (!step_start) check("step_wait", 0, 1);
        step_vector = v;
        step_f = 1'b1;
        tick();
        step_f = 1'b0;
    endtask

    task automatic do_chk(logic conv);
        for (int i = 0; i < 20 && !chk_start; i++) tick();
        if (!chk_start) check("chk_wait", 0, 1);
        chk_f = 1'b1;
        chk_converged = conv;
        tick();
        chk_f = 1'b0;
        chk_converged = 1'b0;
    endtask

    always @(negedge clk) if (rst && step_start && chk_start) check("mutex", 1, 0);

    logic [255:0] s1, s2, s3;

    initial begin
        s1 = vec4(5, 6, 7, 8);
        s2 = vec4(9, 10, 11, 12);
        s3 = vec4(1, 1, 1, 1);
        tick();
        check("rst_busy", busy, 0);
        check("rst_vec", vector, 0);
        rst = 1'b1;
        tick();
        // single converging iteration
        do_start(vec4(1, 2, 3, 4));
        check("t1_step_start", step_start, 1);
        check("t1_busy", busy, 1);
        check("t1_vec", vector, vec4(1, 2, 3, 4));
        check("t1_iter0", iter_count, 0);
        do_step(vec4(2, 2, 2, 2));
        check("t1_chk_start", chk_start, 1);
        check("t1_step_drop", step_start, 0);
        check("t1_next", next_vector, vec4(2, 2, 2, 2));
        do_chk(1);
        check("t1_f", f, 1);
        check("t1_busy_done", busy, 0);
        check("t1_conv", converged, 1);
        check("t1_iter", iter_count, 1);
        check("t1_timeout", timeout, 0);
        tick();
        check("t1_f_drop", f, 0);
        check("t1_hold_next", next_vector, vec4(2, 2, 2, 2));
        check("t1_hold_iter", iter_count, 1);
        // two non-converged verdicts then convergence
        do_start(vec4(1, 2, 3, 4));
        check("t2_iter_clr", iter_count, 0);
        check("t2_conv_clr", converged, 0);
        do_step(s1);
        do_chk(0);
        check("t2_iter1", iter_count, 1);
        check("t2_no_f", f, 0);
        check("t2_chk_low", chk_start, 0);
        tick();
        check("t2_update", vector, s1);
        check("t2_restep", step_start, 1);
        check("t2_chk_low2", chk_start, 0);
        do_step(s2);
        do_chk(0);
        do_step(s3);
        do_chk(1);
        check("t2_vec", vector, s2);
        check("t2_next", next_vector, s3);
        check("t2_iter", iter_count, 3);
        check("t2_conv", converged, 1);
        check("t2_timeout", timeout, 0);
        check("t2_f", f, 1);
        tick();
        // three non-converged verdicts hit the limit
        do_start(vec4(1, 2, 3, 4));
        do_step(s1);
        do_chk(0);
        do_step(s2);
        do_chk(0);
        do_step(s3);
        do_chk(0);
        check("t3_iter", iter_count, 3);
`ifdef EIGEN_ITER_TIMEOUT_EN
        check("t3_f", f, 1);
        check("t3_timeout", timeout, 1);
        check("t3_conv", converged, 0);
        tick();
`else
        check("t3_no_f", f, 0);
        check("t3_timeout", timeout, 0);
        tick();
        check("t3_step4", step_start, 1);
        do_step(s1);
        do_chk(0);
        check("t3_sat", iter_count, 3);
        do_step(s2);
        do_chk(1);
        check("t3_f", f, 1);
        check("t3_conv", converged, 1);
        check("t3_iter_sat", iter_count, 3);
        tick();
`endif
        // stalled step unit with ignored start pulses
        do_start(vec4(1, 2, 3, 4));
        init_vector = vec4(7, 7, 7, 7);
        for (int c = 0; c < 10; c++) begin
            start = (c == 3 || c == 6);
            tick();
            check("t4_hold_step", step_start, 1);
        end
        start = 1'b0;
        check("t4_vec", vector, vec4(1, 2, 3, 4));
        check("t4_busy", busy, 1);
        do_step(s1);
        do_chk(1);
        check("t4_iter", iter_count, 1);
        check("t4_vec_end", vector, vec4(1, 2, 3, 4));
        tick();
        // asynchronous reset during CHECK
        do_start(vec4(1, 2, 3, 4));
        do_step(s2);
        check("t5_in_check", chk_start, 1);
        rst = 1'b0;
        #1;
        check("t5_chk_start", chk_start, 0);
        check("t5_busy", busy, 0);
        check("t5_next", next_vector, 0);
        check("t5_vec", vector, 0);
        tick();
        rst = 1'b1;
        tick();
        do_start(vec4(4, 3, 2, 1));
        check("t5_vec_load", vector, vec4(4, 3, 2, 1));
        do_step(s3);
        do_chk(1);
        check("t5_f", f, 1);
        check("t5_iter", iter_count, 1);
        check("t5_next_end", next_vector, s3);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
